// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 transmitter. Sends one command byte per
//               request over open-collector ps2_clk/ps2_data output-enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES        = 12000,
  parameter int unsigned START_TIMEOUT_CYCLES  = 1500000,
  parameter int unsigned PACKET_TIMEOUT_CYCLES = 200000,
  parameter int unsigned FILTER_LEN            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned        c_fcnt_w    = $clog2(FILTER_LEN) + 1;
  localparam logic [c_fcnt_w-1:0] c_flt_last = c_fcnt_w'(FILTER_LEN - 1);
  localparam logic [31:0]        c_inh_last   = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0]        c_start_last = 32'(START_TIMEOUT_CYCLES - 1);
  localparam logic [31:0]        c_pkt_last   = 32'(PACKET_TIMEOUT_CYCLES - 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_INHIBIT    = 4'd1;
  localparam logic [3:0] S_START      = 4'd2;
  localparam logic [3:0] S_WAIT_FIRST = 4'd3;
  localparam logic [3:0] S_SEND       = 4'd4;
  localparam logic [3:0] S_WAIT_ACK   = 4'd5;
  localparam logic [3:0] S_WAIT_IDLE  = 4'd6;
  localparam logic [3:0] S_DONE       = 4'd7;
  localparam logic [3:0] S_ABORT      = 4'd8;

  // index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {ps2_data_in, ps2_clk_in};

  // Lines idle high, so synchronizers and filters reset to 1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic                r_s1;
    logic                r_s2;
    logic                r_f;
    logic [c_fcnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_f   <= 1'b1;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_f) begin
          r_cnt <= '0;
        end else if (r_cnt == c_flt_last) begin
          r_f   <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_fcnt_w'(1);
        end
      end
    end

    assign w_filt[gi] = r_f;
  end

  logic        r_clk_f_d;
  logic        w_fall;
  logic [3:0]  r_state;
  logic [10:0] r_shift;
  logic [3:0]  r_bitcnt;
  logic [31:0] r_timer;
  logic [31:0] w_timer_inc;
  logic        w_pkt_expired;
  logic        r_clk_oe;
  logic        r_data_oe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_f_d <= 1'b1;
    end else begin
      r_clk_f_d <= w_filt[0];
    end
  end

  assign w_fall        = r_clk_f_d & ~w_filt[0];
  assign w_timer_inc   = (r_timer == '1) ? r_timer : r_timer + 32'd1;
  assign w_pkt_expired = (r_timer >= c_pkt_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_timer   <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_data_oe <= 1'b0;
          if (tx_valid) begin
            r_shift  <= {1'b1, ~^tx_data, tx_data, 1'b0};
            r_bitcnt <= '0;
            r_timer  <= '0;
            r_clk_oe <= 1'b1;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_timer >= c_inh_last) begin
            r_data_oe <= 1'b1;
            r_timer   <= '0;
            r_state   <= S_START;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_START: begin
          r_clk_oe <= 1'b0;
          r_timer  <= '0;
          r_state  <= S_WAIT_FIRST;
        end
        S_WAIT_FIRST: begin
          if (w_fall) begin
            // shift[1] always holds the bit to present after the next fall
            r_data_oe <= ~r_shift[1];
            r_shift   <= r_shift >> 1;
            r_bitcnt  <= 4'd1;
            r_timer   <= '0;
            r_state   <= S_SEND;
          end else if (r_timer >= c_start_last) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= S_ABORT;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_SEND: begin
          r_timer <= w_timer_inc;
          if (w_pkt_expired) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= S_ABORT;
          end else if (w_fall) begin
            r_data_oe <= ~r_shift[1];
            r_shift   <= r_shift >> 1;
            r_bitcnt  <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd9) begin
              r_state <= S_WAIT_ACK;
            end
          end
        end
        S_WAIT_ACK: begin
          r_timer <= w_timer_inc;
          if (w_pkt_expired || (w_fall && w_filt[1])) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= S_ABORT;
          end else if (w_fall) begin
            r_state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          r_timer <= w_timer_inc;
          if (w_pkt_expired) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= S_ABORT;
          end else if (w_filt[0] && w_filt[1]) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ABORT: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign tx_done     = (r_state == S_DONE);
  assign tx_error    = (r_state == S_ABORT);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed bench for ps2_host_tx with a behavioural PS/2 device.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int ST  = 3000;
  localparam int PKT = 2000;
  localparam int H   = 40;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk_low;
  logic       dev_data_low;

  int total;
  int bad;
  int done_cnt;
  int err_cnt;
  int both_cnt;
  logic pulse_d;
  logic ready_after;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (ST),
    .PACKET_TIMEOUT_CYCLES(PKT),
    .FILTER_LEN           (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pulse_d) ready_after <= tx_ready;
    pulse_d <= tx_done | tx_error;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hA5;
  endtask

  // Device side: measures the inhibit, clocks 11 falls, samples on rising edges.
  task automatic dev_frame(input bit ack, input int glitch_at, input int poke_at,
                           output logic [9:0] bits, output int inh_len,
                           output bit start_ok, output bit ok);
    int n;
    ok = 1'b1; inh_len = 0; bits = '0; start_ok = 1'b0; n = 0;
    while (!ps2_clk_oe && n < 50) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) begin ok = 1'b0; return; end
    while (ps2_clk_oe && inh_len < INH + 100) begin
      @(negedge clk);
      if (ps2_clk_oe) inh_len++;
    end
    if (ps2_clk_oe) begin ok = 1'b0; return; end
    start_ok = (ps2_data_in == 1'b0);
    repeat (20) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      if (k == poke_at) begin
        @(negedge clk); tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        repeat (H - 2) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      bits[k-1]   = ps2_data_in;
      if (k == glitch_at) begin
        repeat (10) @(negedge clk); dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);  dev_clk_low = 1'b0;
        repeat (H - 13) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    dev_data_low = ack;
    repeat (H / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (H / 2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (tx_done !== 1'b0 || tx_error !== 1'b0) begin bad++; $display("FAIL reset_pulses: done=%b err=%b want 0/0", tx_done, tx_error); end
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe); end
  endtask

  task automatic test_send_ed();
    logic [9:0] bits; int inh; bit st; bit ok; int d0; int e0;
    d0 = done_cnt; e0 = err_cnt; ready_after = 1'b0;
    start_tx(8'hED);
    total++; if (tx_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL accept: ready=%b busy=%b want 0/1", tx_ready, busy); end
    dev_frame(1'b1, 0, 0, bits, inh, st, ok);
    repeat (40) @(negedge clk);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ed_handshake: ok=%b want 1", ok); end
    total++; if (inh < INH) begin bad++; $display("FAIL ed_inhibit: got %0d cycles want >=%0d", inh, INH); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL ed_start_bit: got %b want 1", st); end
    total++; if (bits !== 10'h3ED) begin bad++; $display("FAIL ed_bits: got %h want 3ed", bits); end
    total++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin bad++; $display("FAIL ed_pulses: done=%0d err=%0d want 1/0", done_cnt - d0, err_cnt - e0); end
    total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL ed_ready_after: got %b want 1", ready_after); end
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL ed_release: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe); end
  endtask

  task automatic test_send_f4();
    logic [9:0] bits; int inh; bit st; bit ok; int d0;
    d0 = done_cnt;
    start_tx(8'hF4);
    dev_frame(1'b1, 0, 0, bits, inh, st, ok);
    repeat (40) @(negedge clk);
    total++; if (bits !== 10'h2F4) begin bad++; $display("FAIL f4_bits: got %h want 2f4", bits); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL f4_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_nack();
    logic [9:0] bits; int inh; bit st; bit ok; int d0; int e0;
    d0 = done_cnt; e0 = err_cnt; ready_after = 1'b0;
    start_tx(8'h00);
    dev_frame(1'b0, 0, 0, bits, inh, st, ok);
    repeat (40) @(negedge clk);
    total++; if (bits !== 10'h300) begin bad++; $display("FAIL nack_bits: got %h want 300", bits); end
    total++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin bad++; $display("FAIL nack_pulses: err=%0d done=%0d want 1/0", err_cnt - e0, done_cnt - d0); end
    total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL nack_ready_after: got %b want 1", ready_after); end
  endtask

  task automatic test_start_timeout();
    int m; int n;
    m = 0;
    start_tx(8'hFF);
    while (ps2_clk_oe && m < INH + 100) begin @(negedge clk); m++; end
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin bad++; $display("FAIL to_release: clk_oe=%b data_oe=%b want 0/1", ps2_clk_oe, ps2_data_oe); end
    n = 1;
    while (!tx_error && n < ST + 100) begin
      @(negedge clk);
      if (!tx_error) n++;
    end
    total++; if (n !== ST) begin bad++; $display("FAIL to_cycles: got %0d want %0d", n, ST); end
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL to_oe: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ignore_valid();
    logic [9:0] bits; int inh; bit st; bit ok; int d0;
    d0 = done_cnt;
    start_tx(8'h0F);
    dev_frame(1'b1, 0, 3, bits, inh, st, ok);
    repeat (40) @(negedge clk);
    total++; if (bits !== 10'h30F) begin bad++; $display("FAIL ign_bits: got %h want 30f", bits); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ign_done: got %0d want 1", done_cnt - d0); end
    repeat (200) @(negedge clk);
    total++; if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin bad++; $display("FAIL ign_no_queue: clk_oe=%b ready=%b want 0/1", ps2_clk_oe, tx_ready); end
  endtask

  task automatic test_reset_midframe();
    int m;
    m = 0;
    start_tx(8'h2C);
    while (ps2_clk_oe && m < INH + 100) begin @(negedge clk); m++; end
    repeat (20) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      dev_clk_low = 1'b1;
      if (k < 5) begin
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (H) @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);
    total++; if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL mid_d4: data_oe=%b want 1", ps2_data_oe); end
    #2 reset = 1'b0;
    #1;
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL mid_async_oe: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_async_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_glitch_ff();
    logic [9:0] bits; int inh; bit st; bit ok; int d0; int e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF);
    dev_frame(1'b1, 4, 0, bits, inh, st, ok);
    repeat (40) @(negedge clk);
    total++; if (bits !== 10'h3FF) begin bad++; $display("FAIL ff_bits: got %h want 3ff", bits); end
    total++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin bad++; $display("FAIL ff_pulses: done=%0d err=%0d want 1/0", done_cnt - d0, err_cnt - e0); end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    total = 0; bad = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
    pulse_d = 1'b0; ready_after = 1'b0;
    reset = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    repeat (20) @(negedge clk);
    test_send_ed();
    test_send_f4();
    test_nack();
    test_start_timeout();
    test_ignore_valid();
    test_reset_midframe();
    test_glitch_ff();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
